// File: rtl/nvme_queue_db_mgr.sv
// NVMe queue pointer and doorbell manager.
// Tracks SQ tail / SQ head / CQ head / CQ phase per queue pair, coalesces
// pointer updates into per-queue pending flags, and issues one doorbell
// write at a time to the PCIe side through a two-state FSM with a
// round-robin arbiter over the interleaved flag list SQ0, CQ0, SQ1, CQ1, ...
//
// Handshakes:
//   sq_push / sq_push_ready : a slot is taken on a rising clock edge where
//     both are high; sq_push while sq_push_ready is low is ignored, with no
//     state change. cq_pop has no back-pressure and is taken on every edge it
//     is high.
//   pcie_write / pcie_wdone : pcie_write (with pcie_waddr / pcie_wdata) rises
//     and then stays high and stable until the edge on which pcie_wdone is
//     high; pcie_werror is only looked at on that same edge. pcie_wdone
//     while pcie_write is low has no effect.

module nvme_queue_db_mgr #(
    parameter int          NUM_Q     = 4,
    parameter int          Q_DEPTH   = 16,
    parameter logic [31:0] DB_BASE   = 32'h1000,
    parameter int          DB_STRIDE = 4,
    localparam int         QID_BITS  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int         PTR_BITS  = $clog2(Q_DEPTH)
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,

    input  logic                sq_push,
    input  logic [QID_BITS-1:0] sq_push_qid,
    output logic                sq_push_ready,
    output logic [PTR_BITS-1:0] sq_slot,

    input  logic                cq_pop,
    input  logic [QID_BITS-1:0] cq_pop_qid,
    input  logic [PTR_BITS-1:0] cq_pop_sqhd,
    output logic [PTR_BITS-1:0] cq_head,
    output logic                cq_phase_exp,

    output logic                pcie_write,
    output logic [31:0]         pcie_waddr,
    output logic [31:0]         pcie_wdata,
    input  logic                pcie_wdone,
    input  logic                pcie_werror,

    output logic                db_busy,
    output logic                db_error,
    output logic [QID_BITS-1:0] db_error_qid,

    output logic                dbg_state
);

    // Number of doorbell flags: one SQ tail and one CQ head flag per pair.
    localparam int NUM_F   = 2 * NUM_Q;
    localparam int RR_BITS = $clog2(NUM_F);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Per-queue pointer state.
    logic [PTR_BITS-1:0] sq_tail_r [NUM_Q];
    logic [PTR_BITS-1:0] sq_head_r [NUM_Q];
    logic [PTR_BITS-1:0] cq_head_r [NUM_Q];
    logic [NUM_Q-1:0]    cq_phase_r;
    logic [NUM_Q-1:0]    sq_pend;
    logic [NUM_Q-1:0]    cq_pend;

    // Doorbell FSM state.
    state_t              state;
    logic [RR_BITS-1:0]  rr_next;
    logic [QID_BITS-1:0] gnt_qid_r;

    // Combinational helpers.
    logic                push_sel_ok;
    logic                pop_sel_ok;
    logic                push_fire;
    logic                pop_fire;
    logic [NUM_F-1:0]    pend_vec;
    logic                gnt_found;
    logic [RR_BITS-1:0]  gnt_idx;
    logic [QID_BITS-1:0] gnt_q;
    logic                gnt_is_cq;
    logic [31:0]         gnt_addr;
    logic [31:0]         gnt_data;
    logic                grant_fire;

    // Flag index arithmetic modulo the flag count (which need not be a power of two).
    function automatic logic [RR_BITS-1:0] wrap_add(input logic [RR_BITS-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_F) begin
            s = s - NUM_F;
        end
        return RR_BITS'(s);
    endfunction

    // Queue selectors outside 0..NUM_Q-1 behave as an always-full, inert queue.
    always_comb begin
        push_sel_ok = (int'(sq_push_qid) < NUM_Q);
        pop_sel_ok  = (int'(cq_pop_qid) < NUM_Q);
    end

    // Producer-side view of the selected SQ: one slot is kept empty to tell full from empty.
    always_comb begin
        sq_push_ready = 1'b0;
        sq_slot       = '0;
        if (push_sel_ok) begin
            sq_slot       = sq_tail_r[sq_push_qid];
            sq_push_ready = ((sq_tail_r[sq_push_qid] + PTR_BITS'(1)) != sq_head_r[sq_push_qid]);
        end
    end

    // Consumer-side view of the selected CQ.
    always_comb begin
        cq_head      = '0;
        cq_phase_exp = 1'b1;
        if (pop_sel_ok) begin
            cq_head      = cq_head_r[cq_pop_qid];
            cq_phase_exp = cq_phase_r[cq_pop_qid];
        end
    end

    // Accepted events for this edge.
    always_comb begin
        push_fire = sq_push && sq_push_ready;
        pop_fire  = cq_pop && pop_sel_ok;
    end

    // Interleave the flags as SQ0, CQ0, SQ1, CQ1, ... so the flag index equals 2*qid + is_cq.
    always_comb begin
        pend_vec = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            pend_vec[2*q]     = sq_pend[q];
            pend_vec[2*q + 1] = cq_pend[q];
        end
    end

    // Round-robin search starting at the flag after the last one granted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_F; k++) begin
            if (!gnt_found && pend_vec[wrap_add(rr_next, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rr_next, k);
            end
        end
    end

    // Doorbell address and pointer value for the flag that would be granted now.
    always_comb begin
        gnt_q      = QID_BITS'(gnt_idx >> 1);
        gnt_is_cq  = gnt_idx[0];
        gnt_addr   = DB_BASE + (32'(gnt_idx) * 32'(DB_STRIDE));
        gnt_data   = gnt_is_cq ? 32'(cq_head_r[gnt_q]) : 32'(sq_tail_r[gnt_q]);
        grant_fire = (state == S_IDLE) && gnt_found;
    end

    // Pointer updates: SQ tail on accepted push, CQ head / SQ head / phase on pop.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            for (int q = 0; q < NUM_Q; q++) begin
                sq_tail_r[q] <= '0;
                sq_head_r[q] <= '0;
                cq_head_r[q] <= '0;
            end
            cq_phase_r <= '1;
        end else begin
            if (push_fire) begin
                sq_tail_r[sq_push_qid] <= sq_tail_r[sq_push_qid] + PTR_BITS'(1);
            end
            if (pop_fire) begin
                cq_head_r[cq_pop_qid] <= cq_head_r[cq_pop_qid] + PTR_BITS'(1);
                sq_head_r[cq_pop_qid] <= cq_pop_sqhd;
                if (cq_head_r[cq_pop_qid] == PTR_BITS'(Q_DEPTH - 1)) begin
                    cq_phase_r[cq_pop_qid] <= ~cq_phase_r[cq_pop_qid];
                end
            end
        end
    end

    // Pending flags: a grant clears its flag, but a new update on the same edge re-arms it.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sq_pend <= '0;
            cq_pend <= '0;
        end else begin
            if (grant_fire) begin
                if (gnt_is_cq) begin
                    cq_pend[gnt_q] <= 1'b0;
                end else begin
                    sq_pend[gnt_q] <= 1'b0;
                end
            end
            if (push_fire) begin
                sq_pend[sq_push_qid] <= 1'b1;
            end
            if (pop_fire) begin
                cq_pend[cq_pop_qid] <= 1'b1;
            end
        end
    end

    // Doorbell FSM: grant and latch in IDLE, hold the write in WAIT until done; errors are not retried.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state        <= S_IDLE;
            pcie_write   <= 1'b0;
            pcie_waddr   <= '0;
            pcie_wdata   <= '0;
            rr_next      <= '0;
            gnt_qid_r    <= '0;
            db_error     <= 1'b0;
            db_error_qid <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        pcie_write <= 1'b1;
                        pcie_waddr <= gnt_addr;
                        pcie_wdata <= gnt_data;
                        gnt_qid_r  <= gnt_q;
                        rr_next    <= wrap_add(gnt_idx, 1);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pcie_wdone) begin
                        pcie_write <= 1'b0;
                        state      <= S_IDLE;
                        if (pcie_werror && !db_error) begin
                            db_error     <= 1'b1;
                            db_error_qid <= gnt_qid_r;
                        end
                    end
                end
                default: begin
                    pcie_write <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Busy while a write is outstanding or any doorbell is still owed.
    always_comb begin
        db_busy   = (state == S_WAIT) || (|sq_pend) || (|cq_pend);
        dbg_state = (state == S_WAIT);
    end

endmodule

// File: tb/tb_nvme_queue_db_mgr.sv
// Testbench for nvme_queue_db_mgr (NUM_Q=4, Q_DEPTH=16).
// A per-cycle reference model of the queue pointers and doorbell traffic is
// compared against the DUT on every cycle, and a set of directed scenarios
// pins hand-computed literal values.

module tb_nvme_queue_db_mgr;

    localparam int          NQ     = 4;
    localparam int          D      = 16;
    localparam logic [31:0] BASE   = 32'h1000;
    localparam int          STRIDE = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        axi_aclk;
    logic        axi_areset;
    logic        sq_push;
    logic [1:0]  sq_push_qid;
    logic        sq_push_ready;
    logic [3:0]  sq_slot;
    logic        cq_pop;
    logic [1:0]  cq_pop_qid;
    logic [3:0]  cq_pop_sqhd;
    logic [3:0]  cq_head;
    logic        cq_phase_exp;
    logic        pcie_write;
    logic [31:0] pcie_waddr;
    logic [31:0] pcie_wdata;
    logic        pcie_wdone;
    logic        pcie_werror;
    logic        db_busy;
    logic        db_error;
    logic [1:0]  db_error_qid;
    logic        dbg_state;

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    nvme_queue_db_mgr #(
        .NUM_Q     (NQ),
        .Q_DEPTH   (D),
        .DB_BASE   (BASE),
        .DB_STRIDE (STRIDE)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_areset    (axi_areset),
        .sq_push       (sq_push),
        .sq_push_qid   (sq_push_qid),
        .sq_push_ready (sq_push_ready),
        .sq_slot       (sq_slot),
        .cq_pop        (cq_pop),
        .cq_pop_qid    (cq_pop_qid),
        .cq_pop_sqhd   (cq_pop_sqhd),
        .cq_head       (cq_head),
        .cq_phase_exp  (cq_phase_exp),
        .pcie_write    (pcie_write),
        .pcie_waddr    (pcie_waddr),
        .pcie_wdata    (pcie_wdata),
        .pcie_wdone    (pcie_wdone),
        .pcie_werror   (pcie_werror),
        .db_busy       (db_busy),
        .db_error      (db_error),
        .db_error_qid  (db_error_qid),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_tail [NQ];
    int          m_head [NQ];
    int          m_cqh  [NQ];
    bit          m_ph   [NQ];
    bit          m_sqp  [NQ];
    bit          m_cqp  [NQ];
    int          m_rr;
    bit          m_wait;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    int          m_gq;
    bit          m_err;
    int          m_errq;

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            m_tail[q] = 0;
            m_head[q] = 0;
            m_cqh[q]  = 0;
            m_ph[q]   = 1'b1;
            m_sqp[q]  = 1'b0;
            m_cqp[q]  = 1'b0;
        end
        m_rr   = 0;
        m_wait = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_gq   = 0;
        m_err  = 1'b0;
        m_errq = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int pq;
        int cq;
        int g;
        bit rdy;
        bit found;
        pq  = int'(sq_push_qid);
        cq  = int'(cq_pop_qid);
        rdy = (((m_tail[pq] + 1) % D) != m_head[pq]);
        if (m_wait) begin
            if (pcie_wdone) begin
                if (pcie_werror && !m_err) begin
                    m_err  = 1'b1;
                    m_errq = m_gq;
                end
                m_wait = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < 2 * NQ; k++) begin
                g = (m_rr + k) % (2 * NQ);
                if (!found && (((g % 2) == 0) ? m_sqp[g / 2] : m_cqp[g / 2])) begin
                    found  = 1'b1;
                    m_gq   = g / 2;
                    m_addr = BASE + 32'(g * STRIDE);
                    if ((g % 2) == 1) begin
                        m_data       = 32'(m_cqh[g / 2]);
                        m_cqp[g / 2] = 1'b0;
                    end else begin
                        m_data       = 32'(m_tail[g / 2]);
                        m_sqp[g / 2] = 1'b0;
                    end
                    m_rr   = (g + 1) % (2 * NQ);
                    m_wait = 1'b1;
                end
            end
        end
        if (sq_push && rdy) begin
            m_tail[pq] = (m_tail[pq] + 1) % D;
            m_sqp[pq]  = 1'b1;
        end
        if (cq_pop) begin
            if (m_cqh[cq] == D - 1) begin
                m_ph[cq] = ~m_ph[cq];
            end
            m_cqh[cq]  = (m_cqh[cq] + 1) % D;
            m_head[cq] = int'(cq_pop_sqhd);
            m_cqp[cq]  = 1'b1;
        end
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic check_outputs();
        int pq;
        int cq;
        bit busy;
        pq   = int'(sq_push_qid);
        cq   = int'(cq_pop_qid);
        busy = m_wait;
        for (int q = 0; q < NQ; q++) begin
            busy = busy | m_sqp[q] | m_cqp[q];
        end
        check("sq_push_ready", 32'(sq_push_ready), 32'(((m_tail[pq] + 1) % D) != m_head[pq]));
        check("sq_slot",       32'(sq_slot),       32'(m_tail[pq]));
        check("cq_head",       32'(cq_head),       32'(m_cqh[cq]));
        check("cq_phase_exp",  32'(cq_phase_exp),  32'(m_ph[cq]));
        check("pcie_write",    32'(pcie_write),    32'(m_wait));
        check("dbg_state",     32'(dbg_state),     32'(m_wait));
        if (m_wait) begin
            check("pcie_waddr", pcie_waddr, m_addr);
            check("pcie_wdata", pcie_wdata, m_data);
        end
        check("db_busy",       32'(db_busy),       32'(busy));
        check("db_error",      32'(db_error),      32'(m_err));
        check("db_error_qid",  32'(db_error_qid),  32'(m_errq));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        sq_push     = 1'b0;
        sq_push_qid = 2'd0;
        cq_pop      = 1'b0;
        cq_pop_qid  = 2'd0;
        cq_pop_sqhd = 4'd0;
        pcie_wdone  = 1'b0;
        pcie_werror = 1'b0;
    endtask

    // One clock: drive at negedge, compare, let the edge happen, step the model.
    task automatic cycle(input bit push, input int pq, input bit pop, input int cqq,
                         input int sqhd, input bit done, input bit err);
        @(negedge axi_aclk);
        sq_push     = push;
        sq_push_qid = 2'(pq);
        cq_pop      = pop;
        cq_pop_qid  = 2'(cqq);
        cq_pop_sqhd = 4'(sqhd);
        pcie_wdone  = done;
        pcie_werror = err;
        #1;
        check_outputs();
        @(posedge axi_aclk);
        model_step();
        #1;
    endtask

    // Asynchronous reset between edges, with the reset state pinned to literals.
    task automatic do_reset();
        @(negedge axi_aclk);
        drive_idle();
        axi_areset = 1'b1;
        #1;
        model_reset();
        check("rst_pcie_write", 32'(pcie_write), 32'd0);
        check("rst_db_busy",    32'(db_busy),    32'd0);
        check("rst_db_error",   32'(db_error),   32'd0);
        check("rst_error_qid",  32'(db_error_qid), 32'd0);
        for (int q = 0; q < NQ; q++) begin
            sq_push_qid = 2'(q);
            cq_pop_qid  = 2'(q);
            #1;
            check("rst_sq_slot",   32'(sq_slot),       32'd0);
            check("rst_sq_ready",  32'(sq_push_ready), 32'd1);
            check("rst_cq_head",   32'(cq_head),       32'd0);
            check("rst_cq_phase",  32'(cq_phase_exp),  32'd1);
        end
        drive_idle();
        @(negedge axi_aclk);
        axi_areset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        axi_areset = 1'b1;
        model_reset();

        // Single SQ2 push: doorbell one cycle later at 0x1010 carrying tail 1.
        do_reset();
        cycle(1, 2, 0, 0, 0, 0, 0);
        check("a_write_not_yet", 32'(pcie_write), 32'd0);
        check("a_busy_pending",  32'(db_busy),    32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("a_write",  32'(pcie_write), 32'd1);
        check("a_waddr",  pcie_waddr,      32'h1010);
        check("a_wdata",  pcie_wdata,      32'd1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("a_write_done", 32'(pcie_write), 32'd0);
        check("a_busy_done",  32'(db_busy),    32'd0);

        // Fill SQ0 with the first doorbell stalled; the second carries the final tail.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
        end
        check("b_full_ready",    32'(sq_push_ready), 32'd0);
        check("b_slot_15",       32'(sq_slot),       32'd15);
        check("b_inflight_addr", pcie_waddr,         32'h1000);
        check("b_inflight_data", pcie_wdata,         32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("b_rejected_slot", 32'(sq_slot), 32'd15);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("b_first_done", 32'(pcie_write), 32'd0);
        check("b_still_busy", 32'(db_busy),    32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("b_second_write", 32'(pcie_write), 32'd1);
        check("b_second_addr",  pcie_waddr,      32'h1000);
        check("b_second_data",  pcie_wdata,      32'd15);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("b_drained", 32'(db_busy), 32'd0);

        // Sixteen pops on CQ1 wrap the head and flip the phase; every doorbell hits 0x100C.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 1, 0, 1, 0);
            if (pcie_write) begin
                check("c_db_addr", pcie_waddr, 32'h100C);
            end
        end
        check("c_cq_head",  32'(cq_head),      32'd0);
        check("c_cq_phase", 32'(cq_phase_exp), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 0, 1, 0);
        end
        check("c_drained", 32'(db_busy), 32'd0);

        // CQ3 in flight while SQ0, CQ0, SQ3 pile up; CQ3 fails, then SQ0, CQ0, SQ3 in order.
        do_reset();
        cycle(0, 0, 1, 3, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        check("d_cq3_addr", pcie_waddr, 32'h101C);
        check("d_cq3_data", pcie_wdata, 32'd1);
        cycle(1, 3, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check("d_error",     32'(db_error),     32'd1);
        check("d_error_qid", 32'(db_error_qid), 32'd3);
        check("d_err_idle",  32'(pcie_write),   32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("d_g1_addr", pcie_waddr, 32'h1000);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("d_g2_addr", pcie_waddr, 32'h1004);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("d_g3_addr", pcie_waddr, 32'h1018);
        check("d_g3_data", pcie_wdata, 32'd1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("d_no_retry",     32'(db_busy),  32'd0);
        check("d_error_sticky", 32'(db_error), 32'd1);

        // Reset in the middle of a write: write drops at once and a late done is ignored.
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("e_write_before", 32'(pcie_write), 32'd1);
        check("e_addr_before",  pcie_waddr,      32'h1008);
        do_reset();
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("e_late_done_write", 32'(pcie_write), 32'd0);
        check("e_late_done_busy",  32'(db_busy),    32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, NQ - 1)),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, NQ - 1)),
                  int'($urandom_range(0, D - 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 0);
        end
        check("rand_drained", 32'(db_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nvme_queue_db_mgr.md
NVME_QUEUE_DB_MGR -- requirements
Module: nvme_queue_db_mgr

Interface
REQ-001 SHALL have parameter NUM_Q, default 4, number of SQ/CQ pairs (1..16); QID_BITS = max(1, clog2(NUM_Q)).
REQ-002 SHALL have parameter Q_DEPTH, default 16, entries per queue (power of 2, >=2); PTR_BITS = clog2(Q_DEPTH).
REQ-003 SHALL have parameter DB_BASE, default 32'h1000, doorbell region base address.
REQ-004 SHALL have parameter DB_STRIDE, default 4, doorbell spacing in bytes.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: axi_aclk  in  1  clock; axi_areset  in  1  asynchronous active-high reset.
REQ-006 SHALL have sq_push  in  1  request to allocate one SQ slot.
REQ-007 SHALL have sq_push_qid  in  QID_BITS  queue for sq_push.
REQ-008 SHALL have sq_push_ready  out  1  slot available in SQ[sq_push_qid], combinational.
REQ-009 SHALL have sq_slot  out  PTR_BITS  current tail of SQ[sq_push_qid], combinational.
REQ-010 SHALL have cq_pop  in  1  consumer has processed the CQ entry at the head.
REQ-011 SHALL have cq_pop_qid  in  QID_BITS  queue for cq_pop and for cq_head/cq_phase_exp.
REQ-012 SHALL have cq_pop_sqhd  in  PTR_BITS  SQ head pointer field carried by the popped entry.
REQ-013 SHALL have cq_head  out  PTR_BITS  head of CQ[cq_pop_qid], combinational.
REQ-014 SHALL have cq_phase_exp  out  1  expected phase bit of CQ[cq_pop_qid], combinational.
REQ-015 SHALL have pcie_write  out  1, pcie_waddr  out  32, pcie_wdata  out  32: doorbell write request.
REQ-016 SHALL have pcie_wdone  in  1, pcie_werror  in  1: write completion; error is valid with done.
REQ-017 SHALL have db_busy  out  1, db_error  out  1 (sticky), db_error_qid  out  QID_BITS.

Function
REQ-018 SHALL keep per queue: sq_tail, sq_head, cq_head (PTR_BITS each), cq_phase (1), sq_db_pend, cq_db_pend.
REQ-019 SHALL assert sq_push_ready iff (sq_tail+1) mod Q_DEPTH != sq_head for the selected queue; one slot stays unused.
REQ-020 SHALL, on sq_push && sq_push_ready at an edge, increment sq_tail modulo Q_DEPTH and set sq_db_pend; sq_push without ready SHALL change nothing.
REQ-021 SHALL, on cq_pop at an edge, increment cq_head modulo Q_DEPTH, load sq_head with cq_pop_sqhd, set cq_db_pend; cq_phase SHALL invert when cq_head wraps Q_DEPTH-1 -> 0.
REQ-022 SHALL accept sq_push and cq_pop in the same cycle, to the same or different queues, with both updates applied.
REQ-023 SHALL run doorbell FSM IDLE -> WAIT -> IDLE; IDLE with any pending flag selects one, latches address/data, clears that flag, enters WAIT next edge.
REQ-024 SHALL arbitrate round-robin over 2*NUM_Q flags ordered SQ0, CQ0, SQ1, CQ1, ..., starting after the last granted flag; after reset search starts at SQ0.
REQ-025 SHALL form pcie_waddr = DB_BASE + (2*qid + is_cq) * DB_STRIDE and pcie_wdata = zero-extended sq_tail (SQ) or cq_head (CQ), sampled at grant.
REQ-026 SHALL hold pcie_write, pcie_waddr, pcie_wdata stable and high throughout WAIT; leave WAIT on the edge pcie_wdone=1; pcie_write low in IDLE.
REQ-027 SHALL coalesce: pushes/pops to a queue while its flag is pending produce one doorbell carrying the latest pointer.
REQ-028 SHALL, when a set and a grant-clear of the same flag coincide, leave the flag set.
REQ-029 SHALL, on pcie_wdone with pcie_werror, set db_error, load db_error_qid with granted qid, and not retry; first error's qid is kept until reset.
REQ-030 SHALL drive db_busy = (state==WAIT) or any flag pending.
REQ-031 SHALL make doorbell latency from accepting edge to pcie_write high exactly 1 cycle when FSM is IDLE and no other flag pending.

Reset
REQ-032 SHALL on axi_areset asynchronously clear all pointers, pending flags, db_error, db_error_qid, RR pointer, state to IDLE; cq_phase resets to 1.
REQ-033 SHALL drop pcie_write immediately on reset mid-WAIT; a later pcie_wdone SHALL be ignored.

Verification
REQ-034 Push SQ2 once (NUM_Q=4) -> next cycle pcie_write=1, waddr=0x1010, wdata=1; pcie_wdone -> pcie_write=0, db_busy=0.
REQ-035 15 pushes to SQ0 with pcie_wdone held off -> sq_push_ready=0 after 15th; one write waddr=0x1000 in flight, second write wdata=15 after done.
REQ-036 16 cq_pop on CQ1 -> cq_head 0, cq_phase_exp 0; 16 cq_pop writes coalesce, each doorbell waddr=0x100C.
REQ-037 SQ0, CQ0, SQ3 all pending simultaneously -> grant order SQ0, CQ0, SQ3 (0x1000, 0x1004, 0x1018).
REQ-038 pcie_wdone+pcie_werror on CQ3 doorbell -> db_error=1, db_error_qid=3, no retry, next pending flag proceeds.
REQ-039 Assert axi_areset during WAIT -> pcie_write=0 same cycle, all pointers 0, cq_phase_exp=1, db_busy=0.
